// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Sequencing controller for the 16-bit multicycle RISC datapath
//            (ADD/ADC/NDU/NDZ/LW/SW/BEQ/JAL). An explicit FSM
//            (FETCH/DECODE/EXEC/MEM/WB/TRAP) waits on the instruction and data
//            memory ready handshakes and traps on a memory timeout or an
//            illegal opcode. It owns the architectural carry/zero flags,
//            resolves the conditional ADC/NDZ writeback, and drives every
//            datapath strobe, mux select and ALU control.
// Options  : `define MC_CTRL_LWZ_FLAG_EN makes LW update zero_flag in WB with
//            the zero test of the loaded data (alu_zero sampled in MEM when
//            dmem_ready arrives). Undefined: LW leaves both flags alone.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16   // max ready wait cycles, legal 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pcsrc,
  output logic        jal,
  output logic        alusrc,
  output logic [1:0]  alucontrol,
  output logic        regdst,
  output logic        memtoreg,
  output logic        rf_we,
  output logic        carry_flag,
  output logic        zero_flag,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [15:0] instret
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [3:0] OP_ADD = 4'b0000;  // ADD / ADC / ADZ family
  localparam logic [3:0] OP_NDU = 4'b0010;  // NDU / NDC / NDZ family
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_JAL = 4'b1101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  // The wait counter starts at 0 on entry, so the last allowed wait cycle is
  // the one where it reads MEM_TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Instruction decode (instr is stable from DECODE until retirement)
  // --------------------------------------------------------------------------
  logic [3:0] opcode;
  logic [1:0] cz_bits;
  logic       is_add, is_ndu, is_lw, is_sw, is_beq, is_jal;
  logic       is_legal, is_adc, is_ndz;
  logic       unused_instr_bits;

  assign opcode   = instr[15:12];
  assign cz_bits  = instr[1:0];
  assign is_add   = (opcode == OP_ADD);
  assign is_ndu   = (opcode == OP_NDU);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_jal   = (opcode == OP_JAL);
  assign is_legal = is_add | is_ndu | is_lw | is_sw | is_beq | is_jal;
  assign is_adc   = is_add & (cz_bits == 2'b10);
  assign is_ndz   = is_ndu & (cz_bits == 2'b01);

  // Register fields and immediates are consumed by the datapath only.
  assign unused_instr_bits = ^instr[11:2];

  // --------------------------------------------------------------------------
  // Internal state
  // --------------------------------------------------------------------------
  logic [2:0] state_next;
  logic [1:0] cause_next;
  logic [7:0] wait_cnt;
  logic       wait_expired;
  logic       commit;
  logic       sel_active;

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign trap         = (state == S_TRAP);

  // Selects are meaningful from DECODE through the retiring state.
  assign sel_active = (state == S_DECODE) || (state == S_EXEC) ||
                      (state == S_MEM)    || (state == S_WB);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, including the trap cause to record on TRAP entry.
  always_comb begin
    state_next = state;
    cause_next = CAUSE_NONE;
    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (is_jal) begin
          state_next = S_WB;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          state_next = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_next = is_sw ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_DMEM_TO;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        // Unused encodings recover to a clean fetch.
        state_next = S_FETCH;
      end
    endcase
  end

  // Output decode: strobes from state and live inputs, selects from instr.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    pcsrc      = 1'b0;
    jal        = 1'b0;
    alusrc     = 1'b0;
    alucontrol = ALU_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;

    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_we = 1'b1;
          pcsrc = alu_zero;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        pc_we    = is_sw & dmem_ready;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = commit;
      end
      default: begin
      end
    endcase

    if (sel_active) begin
      alusrc   = is_lw | is_sw;
      regdst   = is_add | is_ndu;
      memtoreg = is_lw;
      jal      = is_jal;
      if (is_jal) begin
        pcsrc = 1'b1;
      end
      if (is_ndu) begin
        alucontrol = ALU_NAND;
      end else if (is_beq) begin
        alucontrol = ALU_SUB;
      end
    end

    // A reset cycle cancels every side effect, including a pending access.
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
    end
  end

  // Ready-wait counter: saturating, restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state_next != state) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Trap cause captures only the first entry into TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_cause <= CAUSE_NONE;
    end else if ((state != S_TRAP) && (state_next == S_TRAP)) begin
      trap_cause <= cause_next;
    end
  end

  // Commit bit: ADC needs carry set, NDZ needs zero set; all else commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit <= 1'b0;
    end else if (state == S_DECODE) begin
      commit <= !((is_adc && !carry_flag) || (is_ndz && !zero_flag));
    end
  end

`ifdef MC_CTRL_LWZ_FLAG_EN
  logic lw_zero;

  // Zero test of the loaded word, taken from the ALU as the data arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      lw_zero <= 1'b0;
    end else if ((state == S_MEM) && is_lw && dmem_ready) begin
      lw_zero <= alu_zero;
    end
  end
`endif

  // Architectural flags: updated by committed ALU results (and optionally LW).
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if ((state == S_EXEC) && commit) begin
      if (is_add) begin
        carry_flag <= alu_carry;
        zero_flag  <= alu_zero;
      end else if (is_ndu) begin
        zero_flag  <= alu_zero;
      end
    end
`ifdef MC_CTRL_LWZ_FLAG_EN
    else if ((state == S_WB) && is_lw) begin
      zero_flag <= lw_zero;
    end
`endif
  end

  // Retired-instruction counter: every PC update is one retirement.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= 16'd0;
    end else if (pc_we) begin
      instret <= instret + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Self-checking bench for mc_ctrl_fsm: a per-cycle vector table,
//            hand-written trap/reset sequences, and randomized instructions
//            checked against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

  localparam int TIMEOUT = 16;

  localparam logic [15:0] I_ADD = 16'h0298;  // ADD R3,R1,R2
  localparam logic [15:0] I_ADC = 16'h029A;  // ADC R3,R1,R2
  localparam logic [15:0] I_LW  = 16'hA283;
  localparam logic [15:0] I_SW  = 16'h9283;
  localparam logic [15:0] I_BEQ = 16'hB281;
  localparam logic [15:0] I_JAL = 16'hD005;
  localparam logic [15:0] I_BAD = 16'hF000;

  // Strobe vector order: {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we}
  localparam logic [5:0] SB_NONE  = 6'b000000;
  localparam logic [5:0] SB_FETCH = 6'b100100;
  localparam logic [5:0] SB_FWAIT = 6'b100000;
  localparam logic [5:0] SB_WB    = 6'b000011;
  localparam logic [5:0] SB_PC    = 6'b000010;
  localparam logic [5:0] SB_MEM   = 6'b010000;
  localparam logic [5:0] SB_SW    = 6'b011010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pcsrc, jal, alusrc;
  logic [1:0]  alucontrol;
  logic        regdst, memtoreg, rf_we, carry_flag, zero_flag, trap;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [15:0] instret;
  logic [5:0]  strb;

  int n_cmp = 0;
  int n_fail = 0;

  assign strb = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we};

  mc_ctrl_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pcsrc(pcsrc), .jal(jal), .alusrc(alusrc),
    .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg),
    .rf_we(rf_we), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        r;
    logic [15:0] i;
    logic        ir, dr, az, ac;
    logic [2:0]  st;
    logic [5:0]  sb;
    logic        pcs;
    logic [1:0]  cz;     // {carry_flag, zero_flag}
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [15:0] i,
                             input logic ir, input logic dr, input logic az,
                             input logic ac, input logic [2:0] st,
                             input logic [5:0] sb, input logic pcs,
                             input logic [1:0] cz, input logic [15:0] ret);
    vec_t t;
    t.r = r; t.i = i; t.ir = ir; t.dr = dr; t.az = az; t.ac = ac;
    t.st = st; t.sb = sb; t.pcs = pcs; t.cz = cz; t.ret = ret;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, then settle.
  task automatic drive(input logic r, input logic [15:0] i, input logic ir,
                       input logic dr, input logic az, input logic ac);
    @(negedge clk);
    reset = r; instr = i; imem_ready = ir; dmem_ready = dr;
    alu_zero = az; alu_carry = ac;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [3:0]  ops [6];
  logic [15:0] m_ret;
  logic        m_c, m_z;

  initial begin
    int cnt;
    ops[0] = 4'b0000; ops[1] = 4'b0010; ops[2] = 4'b1010;
    ops[3] = 4'b1001; ops[4] = 4'b1011; ops[5] = 4'b1101;

    // ---------------- per-cycle vector table ----------------
    tbl.push_back(v(1, 16'h0, 0,0,0,0, 3'd0, SB_NONE,  0, 2'b00, 16'd0));
    // ADD, ALU result no carry/no zero
    tbl.push_back(v(0, I_ADD, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b00, 16'd0));
    tbl.push_back(v(0, I_ADD, 0,0,0,0, 3'd1, SB_NONE,  0, 2'b00, 16'd0));
    tbl.push_back(v(0, I_ADD, 0,0,0,0, 3'd2, SB_NONE,  0, 2'b00, 16'd0));
    tbl.push_back(v(0, I_ADD, 0,0,0,0, 3'd4, SB_WB,    0, 2'b00, 16'd0));
    // ADD producing carry
    tbl.push_back(v(0, I_ADD, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b00, 16'd1));
    tbl.push_back(v(0, I_ADD, 0,0,0,0, 3'd1, SB_NONE,  0, 2'b00, 16'd1));
    tbl.push_back(v(0, I_ADD, 0,0,0,1, 3'd2, SB_NONE,  0, 2'b00, 16'd1));
    tbl.push_back(v(0, I_ADD, 0,0,0,0, 3'd4, SB_WB,    0, 2'b10, 16'd1));
    // ADC with carry set: commits, flags become {0,0}
    tbl.push_back(v(0, I_ADC, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b10, 16'd2));
    tbl.push_back(v(0, I_ADC, 0,0,0,0, 3'd1, SB_NONE,  0, 2'b10, 16'd2));
    tbl.push_back(v(0, I_ADC, 0,0,0,0, 3'd2, SB_NONE,  0, 2'b10, 16'd2));
    tbl.push_back(v(0, I_ADC, 0,0,0,0, 3'd4, SB_WB,    0, 2'b00, 16'd2));
    // ADD producing zero, no carry
    tbl.push_back(v(0, I_ADD, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b00, 16'd3));
    tbl.push_back(v(0, I_ADD, 0,0,0,0, 3'd1, SB_NONE,  0, 2'b00, 16'd3));
    tbl.push_back(v(0, I_ADD, 0,0,1,0, 3'd2, SB_NONE,  0, 2'b00, 16'd3));
    tbl.push_back(v(0, I_ADD, 0,0,0,0, 3'd4, SB_WB,    0, 2'b01, 16'd3));
    // ADC with carry clear: no write, flags unchanged, still retires
    tbl.push_back(v(0, I_ADC, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b01, 16'd4));
    tbl.push_back(v(0, I_ADC, 0,0,0,0, 3'd1, SB_NONE,  0, 2'b01, 16'd4));
    tbl.push_back(v(0, I_ADC, 0,0,0,1, 3'd2, SB_NONE,  0, 2'b01, 16'd4));
    tbl.push_back(v(0, I_ADC, 0,0,0,0, 3'd4, SB_PC,    0, 2'b01, 16'd4));
    // LW with dmem_ready delayed 3 cycles
    tbl.push_back(v(0, I_LW,  1,0,0,0, 3'd0, SB_FETCH, 0, 2'b01, 16'd5));
    tbl.push_back(v(0, I_LW,  0,0,0,0, 3'd1, SB_NONE,  0, 2'b01, 16'd5));
    tbl.push_back(v(0, I_LW,  0,0,0,0, 3'd2, SB_NONE,  0, 2'b01, 16'd5));
    tbl.push_back(v(0, I_LW,  0,0,1,0, 3'd3, SB_MEM,   0, 2'b01, 16'd5));
    tbl.push_back(v(0, I_LW,  0,0,1,0, 3'd3, SB_MEM,   0, 2'b01, 16'd5));
    tbl.push_back(v(0, I_LW,  0,0,1,0, 3'd3, SB_MEM,   0, 2'b01, 16'd5));
    tbl.push_back(v(0, I_LW,  0,1,1,0, 3'd3, SB_MEM,   0, 2'b01, 16'd5));
    tbl.push_back(v(0, I_LW,  0,0,0,0, 3'd4, SB_WB,    0, 2'b01, 16'd5));
    // SW, zero wait: write, retire from MEM
    tbl.push_back(v(0, I_SW,  1,0,0,0, 3'd0, SB_FETCH, 0, 2'b01, 16'd6));
    tbl.push_back(v(0, I_SW,  0,0,0,0, 3'd1, SB_NONE,  0, 2'b01, 16'd6));
    tbl.push_back(v(0, I_SW,  0,0,0,0, 3'd2, SB_NONE,  0, 2'b01, 16'd6));
    tbl.push_back(v(0, I_SW,  0,1,0,0, 3'd3, SB_SW,    0, 2'b01, 16'd6));
    // BEQ taken, then not taken
    tbl.push_back(v(0, I_BEQ, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b01, 16'd7));
    tbl.push_back(v(0, I_BEQ, 0,0,0,0, 3'd1, SB_NONE,  0, 2'b01, 16'd7));
    tbl.push_back(v(0, I_BEQ, 0,0,1,0, 3'd2, SB_PC,    1, 2'b01, 16'd7));
    tbl.push_back(v(0, I_BEQ, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b01, 16'd8));
    tbl.push_back(v(0, I_BEQ, 0,0,0,0, 3'd1, SB_NONE,  0, 2'b01, 16'd8));
    tbl.push_back(v(0, I_BEQ, 0,0,0,0, 3'd2, SB_PC,    0, 2'b01, 16'd8));
    // JAL: DECODE straight to WB, PC+imm, link write
    tbl.push_back(v(0, I_JAL, 1,0,0,0, 3'd0, SB_FETCH, 0, 2'b01, 16'd9));
    tbl.push_back(v(0, I_JAL, 0,0,0,0, 3'd1, SB_NONE,  1, 2'b01, 16'd9));
    tbl.push_back(v(0, I_JAL, 0,0,0,0, 3'd4, SB_WB,    1, 2'b01, 16'd9));
    tbl.push_back(v(0, 16'h0, 0,0,0,0, 3'd0, SB_FWAIT, 0, 2'b01, 16'd10));

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].i, tbl[k].ir, tbl[k].dr, tbl[k].az, tbl[k].ac);
      check($sformatf("vec%0d state", k), 32'(state), 32'(tbl[k].st));
      check($sformatf("vec%0d strobes", k), 32'(strb), 32'(tbl[k].sb));
      check($sformatf("vec%0d pcsrc", k), 32'(pcsrc), 32'(tbl[k].pcs));
      check($sformatf("vec%0d flags", k), 32'({carry_flag, zero_flag}),
            32'(tbl[k].cz));
      check($sformatf("vec%0d instret", k), 32'(instret), 32'(tbl[k].ret));
    end

    // ---------------- imem timeout ----------------
    do_reset();
    cnt = 0;
    drive(0, I_ADD, 0, 0, 0, 0);
    while (state == 3'd0 && cnt < 300) begin
      cnt++;
      drive(0, I_ADD, 0, 0, 0, 0);
    end
    check("imem_to fetch_cycles", 32'(cnt), 32'(TIMEOUT));
    check("imem_to state", 32'(state), 32'd7);
    check("imem_to trap", 32'(trap), 32'd1);
    check("imem_to cause", 32'(trap_cause), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(0, I_ADD, 1, 1, 1'($urandom), 1'($urandom));
      check($sformatf("imem_to hold%0d strobes", k), 32'(strb), 32'd0);
      check($sformatf("imem_to hold%0d state", k), 32'(state), 32'd7);
      check($sformatf("imem_to hold%0d cause", k), 32'(trap_cause), 32'd1);
    end

    // ---------------- illegal opcode ----------------
    do_reset();
    drive(0, I_BAD, 1, 0, 0, 0);
    check("illegal fetch strobes", 32'(strb), 32'(SB_FETCH));
    drive(0, I_BAD, 0, 0, 0, 0);
    check("illegal decode state", 32'(state), 32'd1);
    drive(0, I_BAD, 1, 1, 0, 0);
    check("illegal state", 32'(state), 32'd7);
    check("illegal cause", 32'(trap_cause), 32'd2);
    check("illegal strobes", 32'(strb), 32'd0);
    check("illegal instret", 32'(instret), 32'd0);

    // ---------------- dmem timeout ----------------
    do_reset();
    drive(0, I_LW, 1, 0, 0, 0);
    drive(0, I_LW, 0, 0, 0, 0);
    drive(0, I_LW, 0, 0, 0, 0);
    cnt = 0;
    drive(0, I_LW, 0, 0, 0, 0);
    while (state == 3'd3 && cnt < 300) begin
      cnt++;
      drive(0, I_LW, 0, 0, 0, 0);
    end
    check("dmem_to mem_cycles", 32'(cnt), 32'(TIMEOUT));
    check("dmem_to state", 32'(state), 32'd7);
    check("dmem_to cause", 32'(trap_cause), 32'd3);
    check("dmem_to strobes", 32'(strb), 32'd0);
    check("dmem_to instret", 32'(instret), 32'd0);

    // ---------------- reset arriving mid-MEM ----------------
    do_reset();
    drive(0, I_ADD, 1, 0, 0, 0);
    drive(0, I_ADD, 0, 0, 0, 0);
    drive(0, I_ADD, 0, 0, 0, 1);
    drive(0, I_ADD, 0, 0, 0, 0);
    drive(0, I_LW, 1, 0, 0, 0);
    check("rstmem pre carry", 32'(carry_flag), 32'd1);
    check("rstmem pre instret", 32'(instret), 32'd1);
    drive(0, I_LW, 0, 0, 0, 0);
    drive(0, I_LW, 0, 0, 0, 0);
    drive(0, I_LW, 0, 0, 0, 0);
    check("rstmem mem state", 32'(state), 32'd3);
    check("rstmem mem dmem_req", 32'(dmem_req), 32'd1);
    drive(1, I_LW, 0, 1, 1, 1);
    check("rstmem reset strobes", 32'(strb), 32'd0);
    drive(0, I_LW, 0, 0, 0, 0);
    check("rstmem post state", 32'(state), 32'd0);
    check("rstmem post flags", 32'({carry_flag, zero_flag}), 32'd0);
    check("rstmem post instret", 32'(instret), 32'd0);
    check("rstmem post trap", 32'(trap), 32'd0);

    // ---------------- randomized instructions vs. model ----------------
    do_reset();
    m_ret = 16'd0; m_c = 1'b0; m_z = 1'b0;
    for (int n = 0; n < 150; n++) begin
      int fw, mw, cyc, fseen, mseen, rfc, dwc, e_cyc, e_rf, e_dw, e_mem;
      logic az, ac, cmt, done;
      logic [15:0] ins;
      logic [3:0] op;
      logic g_pcs, g_m2r, g_rd, g_jal, g_as, e_pcs;
      logic [1:0] g_ac, e_ac;

      fw = $urandom_range(0, 4);
      mw = $urandom_range(0, 4);
      az = 1'($urandom);
      ac = 1'($urandom);
      ins = {ops[$urandom_range(0, 5)], 12'($urandom)};
      op = ins[15:12];

      // Model: one instruction, computed from the ISA rules.
      cmt = !((op == 4'b0000 && ins[1:0] == 2'b10 && !m_c) ||
              (op == 4'b0010 && ins[1:0] == 2'b01 && !m_z));
      case (op)
        4'b0000, 4'b0010: begin e_cyc = fw + 4; e_rf = int'(cmt); end
        4'b1011:          begin e_cyc = fw + 3; e_rf = 0; end
        4'b1101:          begin e_cyc = fw + 3; e_rf = 1; end
        4'b1010:          begin e_cyc = fw + mw + 5; e_rf = 1; end
        default:          begin e_cyc = fw + mw + 4; e_rf = 0; end
      endcase
      e_mem = (op == 4'b1010 || op == 4'b1001) ? mw + 1 : 0;
      e_dw  = (op == 4'b1001) ? mw + 1 : 0;
      e_pcs = (op == 4'b1011) ? az : (op == 4'b1101);
      e_ac  = (op == 4'b0010) ? 2'b10 : (op == 4'b1011) ? 2'b01 : 2'b00;
      if (op == 4'b0000 && cmt) begin
        m_c = ac; m_z = az;
      end else if (op == 4'b0010 && cmt) begin
        m_z = az;
      end
`ifdef MC_CTRL_LWZ_FLAG_EN
      else if (op == 4'b1010) begin
        m_z = az;
      end
`endif
      m_ret = m_ret + 16'd1;

      cyc = 0; fseen = 0; mseen = 0; rfc = 0; dwc = 0; done = 1'b0;
      g_pcs = 0; g_m2r = 0; g_rd = 0; g_jal = 0; g_as = 0; g_ac = 0;
      while (!done && cyc < 100) begin
        @(negedge clk);
        reset = 1'b0; instr = ins; alu_zero = az; alu_carry = ac;
        imem_ready = imem_req && (fseen == fw);
        dmem_ready = dmem_req && (mseen == mw);
        #1;
        cyc++;
        if (imem_req) fseen++;
        if (dmem_req) mseen++;
        if (rf_we) rfc++;
        if (dmem_we) dwc++;
        if (pc_we) begin
          done = 1'b1;
          g_pcs = pcsrc; g_m2r = memtoreg; g_rd = regdst; g_jal = jal;
          g_as = alusrc; g_ac = alucontrol;
        end
      end
      check($sformatf("rnd%0d retired", n), 32'(done), 32'd1);
      check($sformatf("rnd%0d cycles", n), 32'(cyc), 32'(e_cyc));
      check($sformatf("rnd%0d rf_we", n), 32'(rfc), 32'(e_rf));
      check($sformatf("rnd%0d dmem_req", n), 32'(mseen), 32'(e_mem));
      check($sformatf("rnd%0d dmem_we", n), 32'(dwc), 32'(e_dw));
      check($sformatf("rnd%0d pcsrc", n), 32'(g_pcs), 32'(e_pcs));
      check($sformatf("rnd%0d memtoreg", n), 32'(g_m2r), 32'(op == 4'b1010));
      check($sformatf("rnd%0d regdst", n), 32'(g_rd),
            32'(op == 4'b0000 || op == 4'b0010));
      check($sformatf("rnd%0d jal", n), 32'(g_jal), 32'(op == 4'b1101));
      check($sformatf("rnd%0d alusrc", n), 32'(g_as),
            32'(op == 4'b1010 || op == 4'b1001));
      check($sformatf("rnd%0d alucontrol", n), 32'(g_ac), 32'(e_ac));
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d state", n), 32'(state), 32'd0);
      check($sformatf("rnd%0d instret", n), 32'(instret), 32'(m_ret));
      check($sformatf("rnd%0d carry", n), 32'(carry_flag), 32'(m_c));
      check($sformatf("rnd%0d zero", n), 32'(zero_flag), 32'(m_z));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
